// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: ALU opcodes, RV32I opcode constants, immediate formats and the decoded-field record
package decode_stage_pkg;
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_XOR  = 5'd3,
    ALU_SRL  = 5'd4,
    ALU_SRA  = 5'd5,
    ALU_OR   = 5'd6,
    ALU_AND  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_PASS = 5'd9
  } aluop_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  typedef struct packed {
    aluop_e      aluop;
    logic        sign;
    logic [31:0] data1;
    logic [31:0] op2;
    logic [31:0] rs2data;
    logic [31:0] imm;
    logic [11:0] pc;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_fields_t;
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e f);
    return f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           f == IMM_U ? {i[31:12], 12'b0} :
           f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
                        {{20{i[31]}}, i[31:20]};
  endfunction
  function automatic aluop_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLT;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch handshake, writeback port and decoded outputs of the decode stage
interface decode_stage_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [11:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [4:0]  id_aluop;
  logic        id_sign;
  logic [31:0] id_data1;
  logic [31:0] id_op2;
  logic [31:0] id_rs2data;
  logic [31:0] id_imm;
  logic [11:0] id_pc;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        id_branch;
  logic        id_jump;
  logic        id_illegal;
  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, flush, wb_en, wb_rd, wb_data,
    output if_ready, id_valid, id_aluop, id_sign, id_data1, id_op2, id_rs2data, id_imm,
           id_pc, id_rd, id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_illegal
  );
  modport master (
    output if_valid, if_instr, if_pc, ex_ready, flush, wb_en, wb_rd, wb_data,
    input  if_ready, id_valid, id_aluop, id_sign, id_data1, id_op2, id_rs2data, id_imm,
           id_pc, id_rd, id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_illegal
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// regfile: 32x32 register file, two read ports, one write port, write-to-read bypass, x0 hardwired to 0
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] mem [32];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    else if (we && wa != 5'd0)
      mem[wa] <= wd;
  assign rd1 = ra1 == 5'd0 ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : (we && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder with register read and a one-deep valid/ready output register
module decode_stage
  import decode_stage_pkg::*;
(
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  logic [31:0] instr, rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        valid, accept;
  id_fields_t  d, q;
  assign instr = bus.if_instr;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign rd = instr[11:7];
  assign imm_i = imm_gen(instr, IMM_I);
  assign imm_s = imm_gen(instr, IMM_S);
  assign imm_b = imm_gen(instr, IMM_B);
  assign imm_u = imm_gen(instr, IMM_U);
  assign imm_j = imm_gen(instr, IMM_J);
  regfile u_regfile (
    .clk(clk), .reset(reset),
    .ra1(instr[19:15]), .ra2(instr[24:20]), .rd1(rs1v), .rd2(rs2v),
    .we(bus.wb_en), .wa(bus.wb_rd), .wd(bus.wb_data)
  );
  always_comb begin
    d = '0;
    d.pc = bus.if_pc;
    d.rd = rd;
    d.data1 = rs1v;
    d.op2 = rs2v;
    d.rs2data = rs2v;
    case (opc)
      OPC_OP: begin
        d.aluop = alu_of(f3, instr[30]);
        d.sign = f3 == 3'd2 || (f3 == 3'd0 && instr[30]);
        d.regwrite = 1'b1;
      end
      OPC_OPIMM: begin
        d.aluop = alu_of(f3, f3 == 3'd5 && instr[30]);
        d.sign = f3 == 3'd2;
        d.imm = imm_i;
        d.op2 = f3[1:0] == 2'b01 ? {27'b0, instr[24:20]} : imm_i;
        d.regwrite = 1'b1;
      end
      OPC_LOAD: begin
        d.imm = imm_i;
        d.op2 = imm_i;
        d.memread = 1'b1;
        d.regwrite = 1'b1;
      end
      OPC_STORE: begin
        d.imm = imm_s;
        d.op2 = imm_s;
        d.memwrite = 1'b1;
      end
      OPC_BRANCH: begin
        d.aluop = ALU_SUB;
        d.sign = !f3[1];
        d.imm = imm_b;
        d.branch = 1'b1;
      end
      OPC_LUI: begin
        d.aluop = ALU_PASS;
        d.data1 = '0;
        d.imm = imm_u;
        d.op2 = imm_u;
        d.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        d.data1 = {20'b0, bus.if_pc};
        d.imm = imm_u;
        d.op2 = imm_u;
        d.regwrite = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d.data1 = {20'b0, bus.if_pc};
        d.op2 = 32'd4;
        d.imm = opc == OPC_JAL ? imm_j : imm_i;
        d.jump = 1'b1;
        d.regwrite = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    d.regwrite = d.regwrite && rd != 5'd0;
  end
  assign bus.if_ready = !valid || bus.ex_ready;
  assign accept = bus.if_valid && bus.if_ready;
  // flush only kills validity; the held fields are don't-care once id_valid drops
  always_ff @(posedge clk)
    if (reset) begin
      valid <= 1'b0;
      q <= '0;
    end else if (bus.flush)
      valid <= 1'b0;
    else if (accept) begin
      valid <= 1'b1;
      q <= d;
    end else if (bus.ex_ready)
      valid <= 1'b0;
  assign bus.id_valid = valid;
  assign bus.id_aluop = q.aluop;
  assign bus.id_sign = q.sign;
  assign bus.id_data1 = q.data1;
  assign bus.id_op2 = q.op2;
  assign bus.id_rs2data = q.rs2data;
  assign bus.id_imm = q.imm;
  assign bus.id_pc = q.pc;
  assign bus.id_rd = q.rd;
  assign bus.id_regwrite = q.regwrite;
  assign bus.id_memread = q.memread;
  assign bus.id_memwrite = q.memwrite;
  assign bus.id_branch = q.branch;
  assign bus.id_jump = q.jump;
  assign bus.id_illegal = q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios with an expected-output queue for decode_stage
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  decode_stage_if bus();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
  // flags = {regwrite, memread, memwrite, branch, jump, illegal}
  typedef struct packed {
    logic        valid;
    logic [4:0]  aluop;
    logic        sign;
    logic [31:0] data1;
    logic [31:0] op2;
    logic [31:0] rs2data;
    logic [31:0] imm;
    logic [11:0] pc;
    logic [4:0]  rd;
    logic [5:0]  flags;
  } obs_t;
  localparam logic [5:0] RW = 6'b100000, BR = 6'b000100, JP = 6'b000010, IL = 6'b000001;
  obs_t sb[$];
  obs_t e, o;
  int checks = 0, errors = 0;
  function automatic obs_t sample();
    return {bus.id_valid, bus.id_aluop, bus.id_sign, bus.id_data1, bus.id_op2, bus.id_rs2data,
            bus.id_imm, bus.id_pc, bus.id_rd, bus.id_regwrite, bus.id_memread, bus.id_memwrite,
            bus.id_branch, bus.id_jump, bus.id_illegal};
  endfunction
  function automatic obs_t mk(logic [4:0] a, logic s, logic [31:0] d1, logic [31:0] op2,
                              logic [31:0] r2, logic [31:0] imm, logic [11:0] pc,
                              logic [4:0] rd, logic [5:0] f);
    return {1'b1, a, s, d1, op2, r2, imm, pc, rd, f};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] instr, input logic [11:0] pc, input obs_t exp);
    sb.push_back(exp);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc = pc;
    step();
    bus.if_valid = 1'b0;
  endtask
  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en = 1'b1;
    bus.wb_rd = rd;
    bus.wb_data = data;
    step();
    bus.wb_en = 1'b0;
  endtask
  task automatic test_reset();
    o = sample();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", o); end
    checks++;
    if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b want 1", bus.if_ready); end
  endtask
  task automatic test_alu();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    issue(32'h002081B3, 12'h010, mk(5'd0, 1'b0, 32'd5, 32'd7, 32'd7, 32'd0, 12'h010, 5'd3, RW));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL add: got %h want %h", o, e); end
    issue(32'h4030D213, 12'h014, mk(5'd5, 1'b0, 32'd5, 32'd3, 32'd0, 32'h403, 12'h014, 5'd4, RW));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL srai: got %h want %h", o, e); end
    issue(32'hFFF0B293, 12'h018, mk(5'd8, 1'b0, 32'd5, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 12'h018, 5'd5, RW));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL sltiu: got %h want %h", o, e); end
  endtask
  task automatic test_control();
    issue(32'h0020E463, 12'h020, mk(5'd1, 1'b0, 32'd5, 32'd7, 32'd7, 32'd8, 12'h020, 5'd8, BR));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL bltu: got %h want %h", o, e); end
    issue(32'h12345537, 12'h024, mk(5'd9, 1'b0, 32'd0, 32'h12345000, 32'd0, 32'h12345000, 12'h024, 5'd10, RW));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL lui: got %h want %h", o, e); end
    issue(32'h000000EF, 12'h123, mk(5'd0, 1'b0, 32'h123, 32'd4, 32'd0, 32'd0, 12'h123, 5'd1, RW | JP));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL jal: got %h want %h", o, e); end
  endtask
  task automatic test_back_to_back_stall();
    issue(32'h002081B3, 12'h030, mk(5'd0, 1'b0, 32'd5, 32'd7, 32'd7, 32'd0, 12'h030, 5'd3, RW));
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h401103B3;
    bus.if_pc = 12'h034;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL stall_if_ready[%0d]: got %b want 0", i, bus.if_ready); end
      o = sample(); checks++;
      if (o !== sb[0]) begin errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, o, sb[0]); end
      step();
    end
    o = sample(); checks++;
    if (o !== sb[0]) begin errors++; $display("FAIL stall_hold_end: got %h want %h", o, sb[0]); end
    bus.ex_ready = 1'b1;
    sb.push_back(mk(5'd1, 1'b1, 32'd7, 32'd5, 32'd5, 32'd0, 12'h034, 5'd7, RW));
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL release_if_ready: got %b want 1", bus.if_ready); end
    step();
    bus.if_valid = 1'b0;
    void'(sb.pop_front());
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL sub_after_stall: got %h want %h", o, e); end
    step();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.id_valid); end
  endtask
  task automatic test_bypass();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hABCD;
    issue(32'h0000E333, 12'h040, mk(5'd6, 1'b0, 32'hABCD, 32'd0, 32'd0, 32'd0, 12'h040, 5'd6, RW));
    bus.wb_en = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL or_bypass: got %h want %h", o, e); end
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'd1;
    issue(32'h00100013, 12'h044, mk(5'd0, 1'b0, 32'd0, 32'd1, 32'hABCD, 32'd1, 12'h044, 5'd0, 6'b0));
    bus.wb_en = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL addi_x0: got %h want %h", o, e); end
    issue(32'h000004B3, 12'h048, mk(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 12'h048, 5'd9, RW));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL x0_reads_zero: got %h want %h", o, e); end
  endtask
  task automatic test_flush();
    issue(32'h002081B3, 12'h050, mk(5'd0, 1'b0, 32'hABCD, 32'd7, 32'd7, 32'd0, 12'h050, 5'd3, RW));
    bus.ex_ready = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL flush_held: got %h want %h", o, e); end
    bus.flush = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h401103B3;
    #1;
    checks++;
    if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL flush_if_ready: got %b want 0", bus.if_ready); end
    step();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_held_kill: got %b want 0", bus.id_valid); end
    bus.ex_ready = 1'b1;
    #1;
    checks++;
    if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL flush_accept_ready: got %b want 1", bus.if_ready); end
    step();
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_kill: got %b want 0", bus.id_valid); end
  endtask
  task automatic test_reset_stall();
    issue(32'h002081B3, 12'h060, mk(5'd0, 1'b0, 32'hABCD, 32'd7, 32'd7, 32'd0, 12'h060, 5'd3, RW));
    bus.ex_ready = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL prereset_held: got %h want %h", o, e); end
    step();
    reset = 1'b1;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h55;
    bus.if_valid = 1'b1;
    step();
    reset = 1'b0;
    bus.wb_en = 1'b0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    o = sample(); checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_stall_outputs: got %h want 0", o); end
    issue(32'h002081B3, 12'h064, mk(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 12'h064, 5'd3, RW));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL regs_cleared: got %h want %h", o, e); end
  endtask
  task automatic test_illegal();
    issue(32'h0000037F, 12'h070, mk(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 12'h070, 5'd6, IL));
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL illegal: got %h want %h", o, e); end
    step();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", bus.id_valid); end
  endtask
  initial begin
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc = '0;
    bus.ex_ready = 1'b1;
    bus.flush = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_rd = '0;
    bus.wb_data = '0;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_alu();
    test_control();
    test_back_to_back_stall();
    test_bypass();
    test_flush();
    test_reset_stall();
    test_illegal();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
